maze_mover: RTL and testbench

MAZE_MOVER -- requirements
Module: maze_mover

---
 rtl/maze_pkg.sv | 34 +++
 rtl/key_debounce.sv | 43 ++++
 rtl/maze_mover.sv | 162 ++++++++++++++++
 tb/tb_maze_mover.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared maze definitions: grid size, coordinate and move-counter widths,
// FSM encoding and a bounded single-step helper.
package maze_pkg;

   localparam int MAZE_W  = 16;
   localparam int MAZE_H  = 12;
   localparam int COORD_W = 4;
   localparam int MOVES_W = 10;

   localparam logic [MOVES_W-1:0] MOVES_MAX = '1;

   typedef logic [COORD_W-1:0] coord_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_QUERY,
      S_CHECK,
      S_WON
   } state_t;

   typedef struct packed {
      logic   ok;
      coord_t c;
   } step_t;

   // One step down or up; ok is low when the step leaves 0..lim.
   function automatic step_t step_coord(coord_t c, logic dn, coord_t lim);
      step_t s;
      s.ok = dn ? (c != '0) : (c != lim);
      s.c  = dn ? c - coord_t'(1) : c + coord_t'(1);
      return s;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low key conditioner: 2-flop sync, stable-level counter,
// one-cycle press pulse on the accepted 1->0 transition.
module key_debounce #(
   parameter int CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);

   localparam int CW = $clog2(CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

   logic          s1;
   logic          s2;
   logic          level;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1    <= 1'b1;
         s2    <= 1'b1;
         level <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         s1    <= key_n;
         s2    <= s1;
         press <= 1'b0;
         if (s2 == level) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            level <= s2;
            cnt   <= '0;
            press <= ~s2;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/maze_mover.sv
// Player movement controller: debounced keys, wall-ROM lookup of the
// target cell, move counting and goal detection.
module maze_mover
   import maze_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int GRID_W          = MAZE_W,
   parameter int GRID_H          = MAZE_H,
   parameter int START_X         = 0,
   parameter int START_Y         = 0,
   parameter int GOAL_X          = 15,
   parameter int GOAL_Y          = 11
) (
   input  logic               iCLK,
   input  logic               iRST_N,
   input  logic               iAXIS,
   input  logic               iKEY_MINUS,
   input  logic               iKEY_PLUS,
   input  logic               iKEY_RESTART,
   output logic [3:0]         oQ_X,
   output logic [3:0]         oQ_Y,
   input  logic               iWALL,
   output logic [3:0]         oPX,
   output logic [3:0]         oPY,
   output logic [MOVES_W-1:0] oMOVES,
   output logic               oWIN,
   output logic               oMOVE_PULSE
);

   localparam coord_t X_MAX = coord_t'(GRID_W - 1);
   localparam coord_t Y_MAX = coord_t'(GRID_H - 1);
   localparam coord_t SX    = coord_t'(START_X);
   localparam coord_t SY    = coord_t'(START_Y);
   localparam coord_t GX    = coord_t'(GOAL_X);
   localparam coord_t GY    = coord_t'(GOAL_Y);

   logic ev_minus;
   logic ev_plus;
   logic ev_rst;

   key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_minus (
      .clk   (iCLK),
      .rst_n (iRST_N),
      .key_n (iKEY_MINUS),
      .press (ev_minus)
   );

   key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_plus (
      .clk   (iCLK),
      .rst_n (iRST_N),
      .key_n (iKEY_PLUS),
      .press (ev_plus)
   );

   key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
      .clk   (iCLK),
      .rst_n (iRST_N),
      .key_n (iKEY_RESTART),
      .press (ev_rst)
   );

   state_t             state;
   state_t             nxt;
   coord_t             px;
   coord_t             py;
   coord_t             qx;
   coord_t             qy;
   coord_t             tx;
   coord_t             ty;
   step_t              st;
   logic               go;
   logic               at_goal;
   logic [MOVES_W-1:0] moves;
   logic               pulse;

   // MINUS wins over PLUS by steering the step direction.
   always_comb begin
      st = step_coord(iAXIS ? py : px, ev_minus, iAXIS ? Y_MAX : X_MAX);
      tx = px;
      ty = py;
      if (iAXIS) ty = st.c;
      else       tx = st.c;
   end

   always_comb begin
      at_goal = iWALL ? (px == GX && py == GY)
                      : (qx == GX && qy == GY);
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) state <= S_IDLE;
      else         state <= nxt;
   end

   always_comb begin
      nxt = state;
      go  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if ((ev_minus || ev_plus) && st.ok) begin
               nxt = S_QUERY;
               go  = 1'b1;
            end
         end
         S_QUERY: nxt = S_CHECK;
         S_CHECK: nxt = at_goal ? S_WON : S_IDLE;
         S_WON:   nxt = S_WON;
         default: nxt = S_IDLE;
      endcase
      if (ev_rst) begin
         nxt = S_IDLE;
         go  = 1'b0;
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         px    <= SX;
         py    <= SY;
         qx    <= SX;
         qy    <= SY;
         moves <= '0;
         pulse <= 1'b0;
      end else if (ev_rst) begin
         px    <= SX;
         py    <= SY;
         qx    <= SX;
         qy    <= SY;
         moves <= '0;
         pulse <= 1'b0;
      end else begin
         pulse <= 1'b0;
         if (go) begin
            qx <= tx;
            qy <= ty;
         end
         if (state == S_CHECK) begin
            if (!iWALL) begin
               px    <= qx;
               py    <= qy;
               pulse <= 1'b1;
               if (moves != MOVES_MAX) moves <= moves + 1'b1;
            end else begin
               // Blocked: query address falls back onto the player.
               qx <= px;
               qy <= py;
            end
         end
      end
   end

   always_comb begin
      oQ_X        = qx;
      oQ_Y        = qy;
      oPX         = px;
      oPY         = py;
      oMOVES      = moves;
      oWIN        = (state == S_WON);
      oMOVE_PULSE = pulse;
   end

endmodule

// File: tb/tb_maze_mover.sv
// Directed and randomized bench for maze_mover against a grid-rule model
// with an emulated one-cycle-latency wall ROM.
module tb_maze_mover;

   localparam int DEB = 4;
   localparam int W   = 16;
   localparam int H   = 12;
   localparam int GX  = 15;
   localparam int GY  = 11;
   // 2 sync flops + DEB stable samples, then QUERY, CHECK, update.
   localparam int LAT = 2 + DEB + 3;

   logic       iCLK = 1'b0;
   logic       iRST_N = 1'b0;
   logic       iAXIS = 1'b0;
   logic       iKEY_MINUS = 1'b1;
   logic       iKEY_PLUS = 1'b1;
   logic       iKEY_RESTART = 1'b1;
   logic       iWALL = 1'b0;
   logic [3:0] oQ_X;
   logic [3:0] oQ_Y;
   logic [3:0] oPX;
   logic [3:0] oPY;
   logic [9:0] oMOVES;
   logic       oWIN;
   logic       oMOVE_PULSE;

   logic walls [W][H];

   int tests = 0;
   int fails = 0;
   int mx, my, mmoves;
   bit mwin;

   always #10 iCLK = ~iCLK;

   always @(posedge iCLK) iWALL <= walls[oQ_X][oQ_Y];

   maze_mover #(
      .DEBOUNCE_CYCLES (DEB),
      .GRID_W          (W),
      .GRID_H          (H),
      .START_X         (0),
      .START_Y         (0),
      .GOAL_X          (GX),
      .GOAL_Y          (GY)
   ) dut (
      .iCLK         (iCLK),
      .iRST_N       (iRST_N),
      .iAXIS        (iAXIS),
      .iKEY_MINUS   (iKEY_MINUS),
      .iKEY_PLUS    (iKEY_PLUS),
      .iKEY_RESTART (iKEY_RESTART),
      .oQ_X         (oQ_X),
      .oQ_Y         (oQ_Y),
      .iWALL        (iWALL),
      .oPX          (oPX),
      .oPY          (oPY),
      .oMOVES       (oMOVES),
      .oWIN         (oWIN),
      .oMOVE_PULSE  (oMOVE_PULSE)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, ".px"}, 32'(oPX), 0);
      chk({tag, ".py"}, 32'(oPY), 0);
      chk({tag, ".qx"}, 32'(oQ_X), 0);
      chk({tag, ".qy"}, 32'(oQ_Y), 0);
      chk({tag, ".moves"}, 32'(oMOVES), 0);
      chk({tag, ".win"}, 32'(oWIN), 0);
      chk({tag, ".pulse"}, 32'(oMOVE_PULSE), 0);
   endtask

   task automatic model_reset();
      mx = 0;
      my = 0;
      mmoves = 0;
      mwin = 0;
   endtask

   // Grid rules: restart first, MINUS over PLUS, no moves once won.
   task automatic model_step(input bit m, input bit p, input bit r,
                             input bit ax, output int ep, output int eq);
      int d, nx, ny;
      ep = 0;
      eq = 0;
      if (r) begin
         model_reset();
      end else if (!mwin && (m || p)) begin
         d  = m ? -1 : 1;
         nx = mx + (ax ? 0 : d);
         ny = my + (ax ? d : 0);
         if (nx >= 0 && nx < W && ny >= 0 && ny < H) begin
            eq = 2;
            if (!walls[nx][ny]) begin
               mx = nx;
               my = ny;
               if (mmoves < 1023) mmoves++;
               ep = 1;
               mwin = (mx == GX && my == GY);
            end
         end
      end
   endtask

   task automatic sample(inout int qd, inout int pc);
      @(negedge iCLK);
      if (oQ_X !== oPX || oQ_Y !== oPY) qd++;
      if (oMOVE_PULSE === 1'b1) pc++;
   endtask

   task automatic press(input bit m, input bit p, input bit r,
                        input int hold, output int qd, output int pc);
      @(posedge iCLK);
      #1;
      iKEY_MINUS = ~m;
      iKEY_PLUS = ~p;
      iKEY_RESTART = ~r;
      qd = 0;
      pc = 0;
      repeat (hold) sample(qd, pc);
      iKEY_MINUS = 1'b1;
      iKEY_PLUS = 1'b1;
      iKEY_RESTART = 1'b1;
      repeat (16) sample(qd, pc);
   endtask

   task automatic do_move(input bit m, input bit p, input bit r,
                          input bit ax, input string tag);
      int ep, eq, qd, pc;
      iAXIS = ax;
      model_step(m, p, r, ax, ep, eq);
      press(m, p, r, 12, qd, pc);
      chk({tag, ".px"}, 32'(oPX), mx);
      chk({tag, ".py"}, 32'(oPY), my);
      chk({tag, ".moves"}, 32'(oMOVES), mmoves);
      chk({tag, ".win"}, 32'(oWIN), 32'(mwin));
      chk({tag, ".pulses"}, pc, ep);
      chk({tag, ".qcycles"}, qd, eq);
   endtask

   initial begin
      int qd, pc, first_px, first_q;
      bit r, m, ax;

      foreach (walls[x, y]) walls[x][y] = 1'b0;
      model_reset();

      repeat (3) @(posedge iCLK);
      @(negedge iCLK);
      check_reset_vals("reset");
      iRST_N = 1'b1;
      repeat (2) @(negedge iCLK);

      // First move, cycle by cycle from the key drop.
      iAXIS = 1'b0;
      first_px = -1;
      first_q = -1;
      pc = 0;
      @(posedge iCLK);
      #1 iKEY_PLUS = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         @(posedge iCLK);
         #1;
         if (first_px < 0 && oPX === 4'd1) first_px = k;
         if (first_q < 0 && oQ_X === 4'd1) first_q = k;
         if (oMOVE_PULSE === 1'b1) pc++;
      end
      iKEY_PLUS = 1'b1;
      repeat (16) @(negedge iCLK);
      chk("lat.query", first_q, LAT - 2);
      chk("lat.px", first_px, LAT);
      chk("lat.pulses", pc, 1);
      chk("lat.moves", 32'(oMOVES), 1);
      mx = 1;
      mmoves = 1;

      walls[2][0] = 1'b1;
      do_move(0, 1, 0, 0, "wall");
      walls[2][0] = 1'b0;

      do_move(1, 0, 0, 0, "back");
      do_move(1, 0, 0, 0, "edge_x");
      do_move(1, 0, 0, 1, "edge_y");

      iAXIS = 1'b0;
      press(0, 1, 0, 3, qd, pc);
      chk("glitch.px", 32'(oPX), 0);
      chk("glitch.pulses", pc, 0);
      chk("glitch.qcycles", qd, 0);

      for (int i = 0; i < 5; i++) do_move(0, 1, 0, 0, "to55x");
      for (int i = 0; i < 5; i++) do_move(0, 1, 0, 1, "to55y");
      do_move(1, 1, 0, 0, "both");

      // RESTART dropped one edge after PLUS lands while in QUERY.
      iAXIS = 1'b0;
      pc = 0;
      @(posedge iCLK);
      #1 iKEY_PLUS = 1'b0;
      @(posedge iCLK);
      #1 iKEY_RESTART = 1'b0;
      for (int k = 2; k <= 14; k++) begin
         @(posedge iCLK);
         #1;
         if (k == LAT - 2) chk("rsq.query_x", 32'(oQ_X), 5);
         if (k == LAT - 1) begin
            chk("rsq.px", 32'(oPX), 0);
            chk("rsq.py", 32'(oPY), 0);
            chk("rsq.qx", 32'(oQ_X), 0);
            chk("rsq.moves", 32'(oMOVES), 0);
         end
         if (oMOVE_PULSE === 1'b1) pc++;
      end
      iKEY_PLUS = 1'b1;
      iKEY_RESTART = 1'b1;
      repeat (16) @(negedge iCLK);
      chk("rsq.pulses", pc, 0);
      model_reset();

      // Reset asserted while the move sits in CHECK.
      do_move(0, 1, 0, 1, "pre_rst");
      iAXIS = 1'b0;
      @(posedge iCLK);
      #1 iKEY_PLUS = 1'b0;
      repeat (LAT - 1) @(posedge iCLK);
      @(negedge iCLK);
      iRST_N = 1'b0;
      #1;
      check_reset_vals("rst_chk");
      iKEY_PLUS = 1'b1;
      repeat (3) @(negedge iCLK);
      iRST_N = 1'b1;
      repeat (20) @(negedge iCLK);
      chk("rst_chk.after_px", 32'(oPX), 0);
      chk("rst_chk.after_py", 32'(oPY), 0);
      chk("rst_chk.after_moves", 32'(oMOVES), 0);
      model_reset();

      for (int i = 0; i < GX; i++) do_move(0, 1, 0, 0, "walk_x");
      for (int i = 0; i < GY; i++) do_move(0, 1, 0, 1, "walk_y");
      chk("goal.win", 32'(oWIN), 1);
      do_move(1, 0, 0, 0, "won_ign");
      do_move(0, 0, 1, 0, "restart");

      foreach (walls[x, y]) walls[x][y] = ($urandom_range(0, 4) == 0);
      walls[0][0] = 1'b0;
      for (int i = 0; i < 120; i++) begin
         r  = ($urandom_range(0, 9) == 0);
         m  = $urandom_range(0, 1);
         ax = $urandom_range(0, 1);
         do_move(m, ~m, r, ax, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
